// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity constants and default width shared by the UART TX and RX paths
package uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and bit counter feeding the TX line LSB first
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  count,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  logic [DATA_WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  assign ser_bit  = sh[0];
  assign ser_done = count && cnt == CW'(DATA_WIDTH - 1);
  // sh[0] always holds the next data bit to put on the line; counter tracks the bit currently shown
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      sh  <= load ? data : shift ? sh >> 1 : sh;
      cnt <= (load || ser_done) ? '0 : count ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: frame FSM, parity, registered line output and busy flag for the UART transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  tx_state_t state, state_nxt;
  logic accept, par_bit, par_en_q, ser_bit, ser_done, tx_nxt;
  assign accept = state == IDLE && Data_Valid;
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift    (state == START || state == DATA),
    .count    (state == DATA),
    .data     (P_DATA),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );
  // next state and the line value it will drive once registered
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = Data_Valid ? START : IDLE;
      START:   state_nxt = DATA;
      DATA:    state_nxt = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    tx_nxt = state_nxt == START  ? 1'b0 :
             state_nxt == DATA   ? ser_bit :
             state_nxt == PARITY ? par_bit : 1'b1;
  end
  // state, outputs, and frame settings captured at acceptance
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      busy   <= state_nxt != IDLE;
      if (accept) begin
        par_bit  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        par_en_q <= PAR_EN;
      end
    end
  end
endmodule
